// File: rtl/rvx10_hazard_pkg.sv
// Shared types and helpers for the RVX10 pipeline hazard controller.
package rvx10_hazard_pkg;

  localparam int unsigned MC_CNT_W  = 4;
  localparam int unsigned SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  // Saturating increment of a counter that is w bits wide (w <= 64).
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] max_v;
    max_v = (w >= SAT_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/hazard_mc_seq.sv
// Multi-cycle EX op sequencer: holds the pipe for MC_LAT-1 cycles per accepted op.
module hazard_mc_seq
  import rvx10_hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic mc_start,
  output logic mc_hold
);

  mc_state_e             state, next_state;
  logic [MC_CNT_W-1:0]   cnt, next_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // BUSY with cnt==0 is the release cycle: op still in EX, pipe no longer held.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    mc_hold    = 1'b0;
    case (state)
      IDLE: begin
        if (mc_start && (MC_LAT > 1)) begin
          mc_hold    = 1'b1;
          next_state = BUSY;
          next_cnt   = MC_CNT_W'(MC_LAT - 2);
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mc_hold  = 1'b1;
          next_cnt = cnt - MC_CNT_W'(1);
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// RVX10 5-stage pipeline hazard controller: forwarding, load-use stalls,
// branch flushes, multi-cycle EX holds and stall/flush performance counters.
module hazard_ctrl
  import rvx10_hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 3,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             McStartE,
  output logic             EnF,
  output logic             EnD,
  output logic             EnE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic mc_hold;
  logic lw_stall;
  logic pc_accept;

  hazard_mc_seq #(.MC_LAT(MC_LAT)) u_mc_seq (
    .clk      (clk),
    .reset    (reset),
    .mc_start (McStartE),
    .mc_hold  (mc_hold)
  );

  // MEM result is newer than WB, so it wins; x0 is never forwarded.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = FWD_MEM;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = FWD_WB;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = FWD_MEM;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = FWD_WB;
  end

  assign lw_stall = LoadE && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // Priority: multi-cycle hold, then taken branch, then load-use.
  always_comb begin
    EnF       = 1'b1;
    EnD       = 1'b1;
    EnE       = 1'b1;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    pc_accept = 1'b0;
    if (mc_hold) begin
      EnF    = 1'b0;
      EnD    = 1'b0;
      EnE    = 1'b0;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      pc_accept = 1'b1;
    end else if (lw_stall) begin
      EnF    = 1'b0;
      EnD    = 1'b0;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (!EnF)      StallCnt <= CNT_W'(sat_inc(SAT_MAX_W'(StallCnt), CNT_W));
      if (pc_accept) FlushCnt <= CNT_W'(sat_inc(SAT_MAX_W'(FlushCnt), CNT_W));
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed corner cases then random traffic
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned MC_LAT = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int          SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE;
  logic             EnF, EnD, EnE, FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .EnF(EnF), .EnD(EnD), .EnE(EnE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, lde, pcs, mcs;
  } stim_t;

  typedef struct {
    int   tag;
    logic enf, en_d, ene, fd, fe, fm;
    int   fa, fb, sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   tag = 0;
  // Reference model state: cycles the current multi-cycle op still spends in EX.
  int   ex_left = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1'b0; s.rs1d = '0; s.rs2d = '0; s.rs1e = '0; s.rs2e = '0;
    s.rde = '0; s.rdm = '0; s.rdw = '0;
    s.rwm = 1'b0; s.rww = 1'b0; s.lde = 1'b0; s.pcs = 1'b0; s.mcs = 1'b0;
    return s;
  endfunction

  function automatic int fwd_of(input logic [4:0] rs, input stim_t s);
    if (rs == 0) return 0;
    if (s.rwm && s.rdm == rs) return 2;
    if (s.rww && s.rdw == rs) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   hold, lw, acc;
    @(negedge clk);
    reset = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; RegWriteM = s.rwm; RegWriteW = s.rww;
    LoadE = s.lde; PCSrcE = s.pcs; McStartE = s.mcs;
    if (s.rst) begin
      ex_left = 0; m_stall = 0; m_flush = 0;
    end
    if (ex_left == 0) hold = s.mcs && (MC_LAT > 1);
    else              hold = (ex_left > 1);
    lw  = s.lde && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
    acc = !hold && s.pcs;
    e.tag = tag; tag++;
    e.fa = fwd_of(s.rs1e, s);
    e.fb = fwd_of(s.rs2e, s);
    e.enf = !(hold || (!s.pcs && lw));
    e.en_d = e.enf;
    e.ene = !hold;
    e.fd = acc;
    e.fe = acc || (!hold && !s.pcs && lw);
    e.fm = hold;
    e.sc = m_stall;
    e.fc = m_flush;
    exp_q.push_back(e);
    if (!s.rst) begin
      if (ex_left == 0) begin
        if (hold) ex_left = MC_LAT - 1;
      end else begin
        ex_left--;
      end
      if (!e.enf) m_stall = sat(m_stall);
      if (acc)    m_flush = sat(m_flush);
    end
  endtask

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, t, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each step is checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("EnF",       e.tag, 32'(EnF),       32'(e.enf));
        chk("EnD",       e.tag, 32'(EnD),       32'(e.en_d));
        chk("EnE",       e.tag, 32'(EnE),       32'(e.ene));
        chk("FlushD",    e.tag, 32'(FlushD),    32'(e.fd));
        chk("FlushE",    e.tag, 32'(FlushE),    32'(e.fe));
        chk("FlushM",    e.tag, 32'(FlushM),    32'(e.fm));
        chk("ForwardAE", e.tag, 32'(ForwardAE), 32'(e.fa));
        chk("ForwardBE", e.tag, 32'(ForwardBE), 32'(e.fb));
        chk("StallCnt",  e.tag, 32'(StallCnt),  32'(e.sc));
        chk("FlushCnt",  e.tag, 32'(FlushCnt),  32'(e.fc));
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0; McStartE = 1'b0;

    s = idle_stim(); s.rst = 1'b1; apply(s);
    s = idle_stim(); apply(s);
    // forwarding: MEM beats WB, x0 never forwards, WB-only on B
    s = idle_stim(); s.rwm = 1; s.rdm = 5; s.rs1e = 5; s.rww = 1; s.rdw = 5; apply(s);
    s = idle_stim(); s.rwm = 1; s.rdm = 0; s.rs1e = 0; s.rww = 1; s.rdw = 0; apply(s);
    s = idle_stim(); s.rww = 1; s.rdw = 9; s.rs2e = 9; s.rs1e = 9; apply(s);
    // load-use, then branch on top of load-use
    s = idle_stim(); s.lde = 1; s.rde = 7; s.rs2d = 7; apply(s);
    s = idle_stim(); s.pcs = 1; s.lde = 1; s.rde = 7; s.rs1d = 7; apply(s);
    s = idle_stim(); s.lde = 1; s.rde = 0; s.rs1d = 0; apply(s);
    // multi-cycle op with start held high, branch in hold cycle ignored
    s = idle_stim(); s.mcs = 1; apply(s);
    s = idle_stim(); s.mcs = 1; s.pcs = 1; apply(s);
    s = idle_stim(); s.mcs = 1; apply(s);
    s = idle_stim(); apply(s);
    // back-to-back op accepted right after release
    s = idle_stim(); s.mcs = 1; apply(s);
    s = idle_stim(); s.mcs = 1; apply(s);
    s = idle_stim(); s.mcs = 1; apply(s);
    s = idle_stim(); s.mcs = 1; apply(s);
    s = idle_stim(); apply(s);
    // reset in the middle of BUSY
    s = idle_stim(); s.mcs = 1; apply(s);
    s = idle_stim(); s.rst = 1; apply(s);
    s = idle_stim(); apply(s);
    s = idle_stim(); apply(s);
    // saturation of the stall counter
    s = idle_stim(); s.rst = 1; apply(s);
    for (int i = 0; i < SAT + 4; i++) begin
      s = idle_stim(); s.lde = 1; s.rde = 3; s.rs1d = 3; apply(s);
    end
    // random traffic
    s = idle_stim(); s.rst = 1; apply(s);
    for (int i = 0; i < 2000; i++) begin
      s.rst  = ($urandom_range(0, 299) == 0);
      s.rs1d = 5'($urandom_range(0, 7)); s.rs2d = 5'($urandom_range(0, 7));
      s.rs1e = 5'($urandom_range(0, 7)); s.rs2e = 5'($urandom_range(0, 7));
      s.rde  = 5'($urandom_range(0, 7)); s.rdm  = 5'($urandom_range(0, 7));
      s.rdw  = 5'($urandom_range(0, 7));
      s.rwm  = 1'($urandom_range(0, 1)); s.rww  = 1'($urandom_range(0, 1));
      s.lde  = ($urandom_range(0, 3) == 0);
      s.pcs  = ($urandom_range(0, 3) == 0);
      s.mcs  = ($urandom_range(0, 5) == 0) && !s.rst;
      apply(s);
    end
    s = idle_stim(); apply(s);

    repeat (3) @(negedge clk);
    #3;
    nchk++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
